// File: rtl/col_os_sequencer_if.sv
// rtl/col_os_sequencer_if.sv - tile command, stall inputs and core instruction/status bundle
interface col_os_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int K_W    = 7
);
    logic              start;
    logic [K_W-1:0]    num_k;
    logic [ADDR_W-1:0] xmem_base;
    logic [ADDR_W-1:0] pmem_base;
    logic [ADDR_W-1:0] omem_base;
    logic              l0_full;
    logic              ififo_full;
    logic              ofifo_valid;
    logic [50:0]       inst;
    logic              busy;
    logic              done;

    modport master (
        output start, num_k, xmem_base, pmem_base, omem_base,
        output l0_full, ififo_full, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, num_k, xmem_base, pmem_base, omem_base,
        input  l0_full, ififo_full, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/col_os_sequencer.sv
// rtl/col_os_sequencer.sv - output-stationary tile sequencer: fill L0/IFIFO, execute, drain OFIFO to omem
module col_os_sequencer #(
    parameter int ROW    = 8,
    parameter int ADDR_W = 11,
    parameter int K_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    col_os_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EXEC,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    localparam int ST_W = $clog2(ROW + 1);

    localparam int B_LOAD     = 0;
    localparam int B_EXECUTE  = 1;
    localparam int B_L0_WR    = 2;
    localparam int B_L0_RD    = 3;
    localparam int B_IFIFO_RD = 4;
    localparam int B_IFIFO_WR = 5;
    localparam int B_OFIFO_RD = 6;
    localparam int B_A_X      = 7;
    localparam int B_WEN_X    = 18;
    localparam int B_CEN_X    = 19;
    localparam int B_A_P      = 20;
    localparam int B_WEN_P    = 31;
    localparam int B_CEN_P    = 32;
    localparam int B_ACC      = 33;
    localparam int B_A_O      = 36;
    localparam int B_WEN_O    = 47;
    localparam int B_CEN_O    = 48;
    localparam int B_OLM      = 49;
    localparam int B_SFU      = 50;

    // All SRAMs deselected and write-disabled; every strobe, address and mode bit low.
    localparam logic [50:0] IDLE_WORD = (51'd1 << B_CEN_O) | (51'd1 << B_WEN_O)
                                      | (51'd1 << B_CEN_P) | (51'd1 << B_WEN_P)
                                      | (51'd1 << B_CEN_X) | (51'd1 << B_WEN_X);

    state_t            state_q, state_d;
    logic [K_W-1:0]    num_k_q, num_k_d;
    logic [K_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [K_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [K_W-1:0]    ex_cnt_q, ex_cnt_d;
    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic [ADDR_W-1:0] xbase_q, xbase_d;
    logic [ADDR_W-1:0] pbase_q, pbase_d;
    logic [ADDR_W-1:0] obase_q, obase_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [50:0]       inst_q, inst_d;

    logic [ADDR_W-1:0] xaddr, paddr, oaddr;

    assign xaddr = xbase_q + ADDR_W'(rd_cnt_q);
    assign paddr = pbase_q + ADDR_W'(rd_cnt_q);
    assign oaddr = obase_q + ADDR_W'(st_cnt_q);

    always_comb begin
        state_d  = state_q;
        num_k_d  = num_k_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        ex_cnt_d = ex_cnt_q;
        st_cnt_d = st_cnt_q;
        xbase_d  = xbase_q;
        pbase_d  = pbase_q;
        obase_d  = obase_q;
        pend_d   = 1'b0;
        done_d   = 1'b0;
        inst_d   = IDLE_WORD;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_k_d  = bus.num_k;
                    xbase_d  = bus.xmem_base;
                    pbase_d  = bus.pmem_base;
                    obase_d  = bus.omem_base;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    ex_cnt_d = '0;
                    st_cnt_d = '0;
                    if (bus.num_k == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                // pend_q marks an SRAM read visible this cycle; its data lands in L0/IFIFO next cycle.
                if (pend_q) begin
                    inst_d[B_L0_WR]    = 1'b1;
                    inst_d[B_IFIFO_WR] = 1'b1;
                    wr_cnt_d           = wr_cnt_q + K_W'(1);
                end
                if (wr_cnt_q == num_k_q) begin
                    state_d             = S_EXEC;
                    ex_cnt_d            = '0;
                    inst_d[B_EXECUTE]   = 1'b1;
                    inst_d[B_L0_RD]     = 1'b1;
                    inst_d[B_IFIFO_RD]  = 1'b1;
                end else if (rd_cnt_q < num_k_q && !bus.l0_full && !bus.ififo_full) begin
                    inst_d[B_CEN_X]       = 1'b0;
                    inst_d[B_CEN_P]       = 1'b0;
                    inst_d[B_A_X +: 11]   = 11'(xaddr);
                    inst_d[B_A_P +: 11]   = 11'(paddr);
                    rd_cnt_d              = rd_cnt_q + K_W'(1);
                    pend_d                = 1'b1;
                end
            end

            S_EXEC: begin
                ex_cnt_d = ex_cnt_q + K_W'(1);
                if (ex_cnt_q == num_k_q - K_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    inst_d[B_EXECUTE]  = 1'b1;
                    inst_d[B_L0_RD]    = 1'b1;
                    inst_d[B_IFIFO_RD] = 1'b1;
                end
            end

            S_DRAIN: begin
                if (bus.ofifo_valid) begin
                    state_d = S_STORE;
                end
            end

            S_STORE: begin
                if (st_cnt_q == ST_W'(ROW)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (bus.ofifo_valid) begin
                    inst_d[B_OFIFO_RD]  = 1'b1;
                    inst_d[B_SFU]       = 1'b1;
                    inst_d[B_OLM]       = 1'b1;
                    inst_d[B_CEN_O]     = 1'b0;
                    inst_d[B_WEN_O]     = 1'b0;
                    inst_d[B_A_O +: 11] = 11'(oaddr);
                    st_cnt_d            = st_cnt_q + ST_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            num_k_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            ex_cnt_q <= '0;
            st_cnt_q <= '0;
            xbase_q  <= '0;
            pbase_q  <= '0;
            obase_q  <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inst_q   <= IDLE_WORD;
        end else begin
            state_q  <= state_d;
            num_k_q  <= num_k_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            ex_cnt_q <= ex_cnt_d;
            st_cnt_q <= st_cnt_d;
            xbase_q  <= xbase_d;
            pbase_q  <= pbase_d;
            obase_q  <= obase_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            inst_q   <= inst_d;
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
